// File: rtl/prbs_tx_pkg.sv
// Shared definitions for the PRBS transmit frame sequencer: FSM state encoding,
// BPSK chip mapping and the lane-enable mask for a partially filled last word.
package prbs_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_TX,
    S_GUARD
  } state_t;

  // Chip 0 maps to +A and chip 1 to -A; callers truncate to their sample width.
  function automatic logic [31:0] bpsk_map(input logic chip, input logic [31:0] amp);
    return chip ? (~amp + 32'd1) : amp;
  endfunction

  // A zero remainder means the last word is full, so every lane stays enabled.
  function automatic logic [31:0] lane_mask(input logic [31:0] rem);
    return (rem == 32'd0) ? '1 : ((32'd1 << rem) - 32'd1);
  endfunction

endpackage

// File: rtl/prbs_tx_bpsk_mapper.sv
// Combinational chip-to-sample mapper: each enabled lane carries +A/-A for its chip,
// disabled lanes carry zero.
module prbs_tx_bpsk_mapper
  import prbs_tx_pkg::*;
#(
  parameter int unsigned PARALLEL_WIDTH = 8,
  parameter int unsigned SAMPLE_WIDTH   = 16
) (
  input  logic [PARALLEL_WIDTH-1:0]              i_chips,
  input  logic [SAMPLE_WIDTH-1:0]                i_amplitude,
  input  logic [PARALLEL_WIDTH-1:0]              i_lane_en,
  output logic [PARALLEL_WIDTH*SAMPLE_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < PARALLEL_WIDTH; i++) begin
      if (i_lane_en[i])
        o_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
          SAMPLE_WIDTH'(bpsk_map(i_chips[i], 32'(i_amplitude)));
    end
  end

endmodule

// File: rtl/prbs_tx_frame_sequencer.sv
// Frames the parallel PRBS stream into N seed-restarted BPSK pulses with guard gaps.
// Optional `PRBS_TX_STALL_STATS_EN adds a saturating stall_cycles counter output.
module prbs_tx_frame_sequencer
  import prbs_tx_pkg::*;
#(
  parameter int unsigned PARALLEL_WIDTH  = 8,
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned CHIP_CNT_WIDTH  = 20,
  parameter int unsigned PULSE_CNT_WIDTH = 16,
  parameter int unsigned GUARD_WIDTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [CHIP_CNT_WIDTH-1:0]              cfg_code_len,
  input  logic [PULSE_CNT_WIDTH-1:0]             cfg_num_pulses,
  input  logic [GUARD_WIDTH-1:0]                 cfg_guard_cycles,
  input  logic [SAMPLE_WIDTH-1:0]                cfg_amplitude,
  output logic                                   gen_enable,
  output logic                                   gen_sync_reset,
  input  logic [PARALLEL_WIDTH-1:0]              prbs_in,
  output logic [PARALLEL_WIDTH*SAMPLE_WIDTH-1:0] tx_data,
  output logic                                   tx_valid,
  input  logic                                   tx_ready,
  output logic                                   tx_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   cfg_error
`ifdef PRBS_TX_STALL_STATS_EN
  ,
  output logic [31:0]                            stall_cycles
`endif
);

  localparam int unsigned LOG2 = $clog2(PARALLEL_WIDTH);

  state_t                                r_state;
  logic [CHIP_CNT_WIDTH-1:0]             r_words;
  logic [LOG2-1:0]                       r_rem;
  logic [PULSE_CNT_WIDTH-1:0]            r_num_pulses;
  logic [GUARD_WIDTH-1:0]                r_guard;
  logic [SAMPLE_WIDTH-1:0]               r_amp;
  logic [CHIP_CNT_WIDTH-1:0]             r_word_cnt;
  logic [PULSE_CNT_WIDTH-1:0]            r_pulse_cnt;
  logic [GUARD_WIDTH-1:0]                r_guard_cnt;
  logic [PARALLEL_WIDTH*SAMPLE_WIDTH-1:0] r_tx_data;
  logic                                  r_tx_valid;
  logic                                  r_tx_last;
  logic                                  r_done;
  logic                                  r_done_pend;
  logic                                  r_cfg_error;

  logic                                  w_gen_enable;
  logic                                  w_accept;
  logic                                  w_out_free;
  logic                                  w_last_word;
  logic                                  w_start_take;
  logic                                  w_cfg_zero;
  logic [CHIP_CNT_WIDTH-1:0]             w_words_calc;
  logic [PARALLEL_WIDTH-1:0]             w_lane_en;
  logic [PARALLEL_WIDTH*SAMPLE_WIDTH-1:0] w_mapped;

  assign w_accept     = r_tx_valid && tx_ready;
  assign w_out_free   = !r_tx_valid || tx_ready;
  assign w_gen_enable = (r_state == S_TX) && w_out_free;
  assign w_last_word  = (r_word_cnt == r_words - CHIP_CNT_WIDTH'(1));
  assign w_start_take = (r_state == S_IDLE) && start && !abort;
  assign w_cfg_zero   = (cfg_code_len == '0) || (cfg_num_pulses == '0);
  // Ceiling divide by the power-of-two lane count: shift, then round up on any remainder.
  assign w_words_calc = (cfg_code_len >> LOG2) + CHIP_CNT_WIDTH'(|cfg_code_len[LOG2-1:0]);
  assign w_lane_en    = w_last_word ? PARALLEL_WIDTH'(lane_mask(32'(r_rem))) : '1;

  prbs_tx_bpsk_mapper #(
    .PARALLEL_WIDTH (PARALLEL_WIDTH),
    .SAMPLE_WIDTH   (SAMPLE_WIDTH)
  ) u_mapper (
    .i_chips     (prbs_in),
    .i_amplitude (r_amp),
    .i_lane_en   (w_lane_en),
    .o_data      (w_mapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_words      <= '0;
      r_rem        <= '0;
      r_num_pulses <= '0;
      r_guard      <= '0;
      r_amp        <= '0;
      r_word_cnt   <= '0;
      r_pulse_cnt  <= '0;
      r_guard_cnt  <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_last    <= 1'b0;
      r_done       <= 1'b0;
      r_done_pend  <= 1'b0;
      r_cfg_error  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_cfg_error <= 1'b0;
      if (w_accept) begin
        r_tx_valid <= 1'b0;
        r_tx_last  <= 1'b0;
        if (r_done_pend) begin
          r_done      <= 1'b1;
          r_done_pend <= 1'b0;
        end
      end
      if (abort) begin
        r_state     <= S_IDLE;
        r_tx_valid  <= 1'b0;
        r_tx_last   <= 1'b0;
        r_word_cnt  <= '0;
        r_pulse_cnt <= '0;
        r_guard_cnt <= '0;
        r_done_pend <= 1'b0;
        r_done      <= (r_state != S_IDLE) || (w_accept && r_done_pend);
      end else begin
        case (r_state)
          S_IDLE: if (w_start_take) begin
            r_words      <= w_words_calc;
            r_rem        <= cfg_code_len[LOG2-1:0];
            r_num_pulses <= cfg_num_pulses;
            r_guard      <= cfg_guard_cycles;
            r_amp        <= cfg_amplitude;
            r_word_cnt   <= '0;
            r_pulse_cnt  <= '0;
            if (w_cfg_zero) r_cfg_error <= 1'b1;
            else            r_state     <= S_SYNC;
          end
          S_SYNC: begin
            r_word_cnt <= '0;
            r_state    <= S_TX;
          end
          S_TX: if (w_gen_enable) begin
            r_tx_data  <= w_mapped;
            r_tx_valid <= 1'b1;
            r_tx_last  <= w_last_word;
            r_word_cnt <= r_word_cnt + CHIP_CNT_WIDTH'(1);
            if (w_last_word) begin
              r_word_cnt  <= '0;
              r_pulse_cnt <= r_pulse_cnt + PULSE_CNT_WIDTH'(1);
              if ((r_pulse_cnt + PULSE_CNT_WIDTH'(1)) == r_num_pulses) begin
                r_state     <= S_IDLE;
                r_done_pend <= 1'b1;
              end else if (r_guard == '0) begin
                r_state <= S_SYNC;
              end else begin
                r_state     <= S_GUARD;
                r_guard_cnt <= '0;
              end
            end
          end
          // Guard count finishes first; SYNC is then held off until the output slot frees.
          S_GUARD: begin
            if (r_guard_cnt != r_guard - GUARD_WIDTH'(1))
              r_guard_cnt <= r_guard_cnt + GUARD_WIDTH'(1);
            else if (w_out_free)
              r_state <= S_SYNC;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PRBS_TX_STALL_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (w_start_take)
      r_stall_cycles <= '0;
    else if (r_tx_valid && !tx_ready && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign gen_enable     = w_gen_enable;
  assign gen_sync_reset = (r_state == S_SYNC);
  assign busy           = (r_state != S_IDLE);
  assign tx_data        = r_tx_data;
  assign tx_valid       = r_tx_valid;
  assign tx_last        = r_tx_last;
  assign done           = r_done;
  assign cfg_error      = r_cfg_error;

endmodule

// File: tb/tb_prbs_tx_frame_sequencer.sv
// Self-checking bench for prbs_tx_frame_sequencer: an index-based PRBS-15 source drives
// prbs_in and a word-level reference model built from the chip sequence checks tx_data.
module tb_prbs_tx_frame_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [19:0]  cfg_code_len;
  logic [15:0]  cfg_num_pulses;
  logic [15:0]  cfg_guard_cycles;
  logic [15:0]  cfg_amplitude;
  logic         gen_enable;
  logic         gen_sync_reset;
  logic [7:0]   prbs_in;
  logic [127:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;
  logic         busy;
  logic         done;
  logic         cfg_error;
`ifdef PRBS_TX_STALL_STATS_EN
  logic [31:0]  stall_cycles;
`endif

  prbs_tx_frame_sequencer #(
    .PARALLEL_WIDTH  (8),
    .SAMPLE_WIDTH    (16),
    .CHIP_CNT_WIDTH  (20),
    .PULSE_CNT_WIDTH (16),
    .GUARD_WIDTH     (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .cfg_code_len     (cfg_code_len),
    .cfg_num_pulses   (cfg_num_pulses),
    .cfg_guard_cycles (cfg_guard_cycles),
    .cfg_amplitude    (cfg_amplitude),
    .gen_enable       (gen_enable),
    .gen_sync_reset   (gen_sync_reset),
    .prbs_in          (prbs_in),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_last          (tx_last),
    .busy             (busy),
    .done             (done),
    .cfg_error        (cfg_error)
`ifdef PRBS_TX_STALL_STATS_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  typedef struct packed {
    logic [127:0] d;
    logic         l;
    logic         f;
  } exp_t;

  bit           seq [0:8191];
  int           gen_idx;
  exp_t         exp_q[$];
  int           ps[$];
  logic [127:0] acc_q[$];
  logic [127:0] last_word;
  logic [127:0] prev_data;
  logic         prev_stall;
  logic         prev_last;
  int n_cmp = 0;
  int n_fail = 0;
  int cycle_n = 0;
  int nacc, last_acc, done_cnt, done_cycle, sync_cnt, stall_seen;
  int ready_pct = 100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator stand-in: sync_reset rewinds to the seed, enable advances 8 chips.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gen_idx <= 0;
    else if (gen_sync_reset) gen_idx <= 0;
    else if (gen_enable)     gen_idx <= (gen_idx + 8) % 8192;
  end

  always_comb begin
    prbs_in = '0;
    for (int i = 0; i < 8; i++) prbs_in[i] = seq[(gen_idx + i) % 8192];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cycle_n++;
    if (prev_stall) begin
      chk("hold_valid", 128'(tx_valid), 128'(1));
      chk("hold_data", tx_data, prev_data);
      chk("hold_last", 128'(tx_last), 128'(prev_last));
    end
    if (tx_valid && !tx_ready) begin
      chk("stall_gen_en", 128'(gen_enable), 128'(0));
      stall_seen++;
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("extra_word", 128'(tx_valid), 128'(0));
      else begin
        e = exp_q.pop_front();
        chk("word_data", tx_data, e.d);
        chk("word_last", 128'(tx_last), 128'(e.l));
        if (e.f) ps.push_back(cycle_n);
        if (e.l) last_word = tx_data;
      end
      nacc++;
      last_acc = cycle_n;
      acc_q.push_back(tx_data);
    end
    if (done) begin done_cnt++; done_cycle = cycle_n; end
    if (gen_sync_reset) sync_cnt++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_last  = tx_last;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    tx_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
    #1;
  endtask

  task automatic load_cfg(input int cl, input int np, input int g, input logic [15:0] amp);
    cfg_code_len     = 20'(cl);
    cfg_num_pulses   = 16'(np);
    cfg_guard_cycles = 16'(g);
    cfg_amplitude    = amp;
    exp_q.delete(); ps.delete(); acc_q.delete();
    nacc = 0; last_acc = -1; done_cnt = 0; done_cycle = -1; sync_cnt = 0; stall_seen = 0;
  endtask

  // Expected words straight from the chip sequence: chip c of every pulse is seq[c].
  task automatic build_model(input int cl, input int np, input logic [15:0] amp);
    int w;
    int c;
    logic [15:0]  neg;
    logic [127:0] d;
    exp_t e;
    w   = (cl + 7) / 8;
    neg = 16'(65536 - int'(amp));
    for (int p = 0; p < np; p++)
      for (int k = 0; k < w; k++) begin
        d = '0;
        for (int i = 0; i < 8; i++) begin
          c = k * 8 + i;
          if (c < cl) d[i*16 +: 16] = seq[c] ? neg : amp;
        end
        e.d = d; e.l = (k == w - 1); e.f = (k == 0);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while ((busy || tx_valid) && b > 0) begin cyc(); b--; end
    chk("idle_timeout", 128'({busy, tx_valid}), 128'(0));
    cyc(); cyc();
    chk("words_remaining", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic wait_acc(input int n, input int budget);
    int b;
    b = budget;
    while (nacc < n && b > 0) begin cyc(); b--; end
    chk("acc_timeout", 128'(nacc >= n), 128'(1));
  endtask

  initial begin
    int c0;
    int gap;
    logic [127:0] wd;
    logic [14:0]  lfsr;
    lfsr = '1;
    for (int i = 0; i < 8192; i++) begin
      seq[i] = lfsr[14] ^ lfsr[13];
      lfsr   = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; last_word = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    load_cfg(0, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(tx_valid), 128'(0));
    chk("rst_data", tx_data, 128'(0));
    chk("rst_gen", 128'({gen_enable, gen_sync_reset, tx_last, done, cfg_error}), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk("post_rst_outs", 128'({busy, tx_valid, gen_enable, gen_sync_reset, done}), 128'(0));

    // Long code, partial last word, guard between two pulses, checked cycle by cycle at start.
    load_cfg(2047, 2, 5, 16'h4000);
    build_model(2047, 2, 16'h4000);
    start = 1'b1;
    cyc(); c0 = cycle_n;
    chk("c1_sync", 128'({gen_sync_reset, busy, gen_enable}), 128'(3'b110));
    cyc();
    chk("c2_gen_en", 128'({gen_enable, tx_valid}), 128'(2'b10));
    cyc();
    chk("c3_valid", 128'(tx_valid), 128'(1));
    wait_idle(2000);
    chk("a_words", 128'(nacc), 128'(512));
    chk("a_lane7", 128'(last_word[127:112]), 128'(0));
    gap = (ps.size() >= 2) ? ps[1] - ps[0] : -1;
    chk("a_period", 128'(gap), 128'(262));
    chk("a_first_word", 128'(ps.size() >= 1 ? ps[0] : -1), 128'(c0 + 3));
    chk("a_sync_cnt", 128'(sync_cnt), 128'(2));
    chk("a_done_cnt", 128'(done_cnt), 128'(1));
    chk("a_done_time", 128'(done_cycle), 128'(last_acc + 1));

    // Short code: exact word count and explicit +A / -A lane values.
    load_cfg(16, 1, 3, 16'h4000);
    build_model(16, 1, 16'h4000);
    start = 1'b1; cyc();
    wait_idle(200);
    chk("b_words", 128'(nacc), 128'(2));
    for (int w = 0; w < 2; w++) begin
      wd = (acc_q.size() > w) ? acc_q[w] : '0;
      for (int i = 0; i < 8; i++)
        chk("b_lane", 128'(wd[i*16 +: 16]), 128'(seq[w*8+i] ? 16'hC000 : 16'h4000));
    end

    // Random back-pressure at 30% ready with random code length, guard and amplitude.
    ready_pct = 30;
    begin
      int cl; int g; logic [15:0] amp;
      cl  = int'($urandom_range(1, 300));
      g   = int'($urandom_range(0, 4));
      amp = 16'($urandom_range(1, 16'h7fff));
      load_cfg(cl, 3, g, amp);
      build_model(cl, 3, amp);
      start = 1'b1; cyc();
      wait_idle(8000);
      chk("c_words", 128'(nacc), 128'(3 * ((cl + 7) / 8)));
      chk("c_done_cnt", 128'(done_cnt), 128'(1));
`ifdef PRBS_TX_STALL_STATS_EN
      chk("c_stall_cycles", 128'(stall_cycles), 128'(stall_seen));
`endif
    end
    ready_pct = 100;
    cyc();

    // Abort in the middle of pulse 3 of 4, then a fresh burst must restart at the seed.
    load_cfg(64, 4, 2, 16'h1234);
    build_model(64, 4, 16'h1234);
    start = 1'b1; cyc();
    wait_acc(19, 300);
    abort = 1'b1; cyc();
    chk("d_valid_low", 128'(tx_valid), 128'(0));
    chk("d_done", 128'(done), 128'(1));
    chk("d_idle", 128'(busy), 128'(0));
    exp_q.delete();
    cyc(); cyc();
    load_cfg(64, 1, 0, 16'h0777);
    build_model(64, 1, 16'h0777);
    start = 1'b1; cyc();
    wait_idle(200);
    chk("d2_words", 128'(nacc), 128'(8));

    // Zero pulse count and zero code length are rejected.
    load_cfg(100, 0, 1, 16'h4000);
    start = 1'b1; cyc();
    chk("e_cfg_err", 128'({cfg_error, busy, done}), 128'(3'b100));
    cyc();
    chk("e_after", 128'({cfg_error, busy, done}), 128'(0));
    load_cfg(0, 2, 1, 16'h4000);
    start = 1'b1; cyc();
    chk("e_len0_err", 128'({cfg_error, busy}), 128'(2'b10));
    cyc();

    // Abort and start in the same cycle: abort wins.
    load_cfg(40, 1, 0, 16'h4000);
    start = 1'b1; abort = 1'b1; cyc();
    chk("f_abort_start", 128'({busy, cfg_error, done}), 128'(0));
    cyc();
    chk("f_abort_start2", 128'({busy, tx_valid, done}), 128'(0));

    // Zero guard: back-to-back pulses, and a start while busy is ignored.
    load_cfg(24, 2, 0, 16'h2000);
    build_model(24, 2, 16'h2000);
    start = 1'b1; cyc();
    cyc();
    cfg_num_pulses = 16'd5; start = 1'b1; cyc();
    wait_idle(200);
    chk("g_words", 128'(nacc), 128'(6));
    gap = (ps.size() >= 2) ? ps[1] - ps[0] : -1;
    chk("g_period", 128'(gap), 128'(4));
    chk("g_done_cnt", 128'(done_cnt), 128'(1));

    // Asynchronous reset in the middle of a burst.
    load_cfg(200, 2, 3, 16'h4000);
    build_model(200, 2, 16'h4000);
    start = 1'b1; cyc();
    repeat (10) cyc();
    rst_n = 1'b0;
    #1;
    chk("r_outs", 128'({busy, tx_valid, gen_enable, gen_sync_reset, tx_last, done}), 128'(0));
    chk("r_data", tx_data, 128'(0));
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete(); prev_stall = 1'b0;
    cyc(); cyc();
    chk("r_idle", 128'({busy, tx_valid}), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
